// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types: FSM state encoding, queue entry layout and PC alignment.
package rv32i_types;

    typedef enum logic [1:0] {
        WAIT,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of I-cache request/response, redirect and decode-side queue signals.
interface fetch_unit_if;
    logic        mem_i_read;
    logic [31:0] mem_i_address;
    logic        mem_i_resp;
    logic [31:0] mem_i_rdata_cpu;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_ready;

    modport master (
        output mem_i_read, mem_i_address, iq_valid, iq_instr, iq_pc,
        input  mem_i_resp, mem_i_rdata_cpu, redirect_valid, redirect_pc, iq_ready
    );

    modport slave (
        input  mem_i_read, mem_i_address, iq_valid, iq_instr, iq_pc,
        output mem_i_resp, mem_i_rdata_cpu, redirect_valid, redirect_pc, iq_ready
    );
endinterface

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue of {pc, instr} entries; flush overrides push and pop.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int IQ_DEPTH = 8,
    localparam int CW = $clog2(IQ_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  iq_entry_t     i_pushData,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output iq_entry_t     o_head
);
    localparam int PW = $clog2(IQ_DEPTH);

    iq_entry_t     r_mem [IQ_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = i_push && (r_count != CW'(IQ_DEPTH));
    assign w_doPop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_tail <= r_tail + PW'(1);
            if (w_doPop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    // Storage needs no reset: the count decides which slots are visible.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush && !rst) r_mem[r_tail] <= i_pushData;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one outstanding I-cache request,
// redirect/drain handling. Optional same-cycle queue bypass under FETCH_IQ_BYPASS_EN.
module fetch_unit
    import rv32i_types::*;
#(
    parameter int          IQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_stateNext;
    logic [31:0]   r_addr;
    logic [31:0]   w_addrNext;
    logic [31:0]   r_pend;
    logic [31:0]   w_pendNext;
    logic [31:0]   w_redirPc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_countNext;
    iq_entry_t     w_head;
    iq_entry_t     w_pushEntry;
    logic          w_empty;
    logic          w_resp;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_space;

    assign w_redirPc = align_pc(bus.redirect_pc);
    assign w_empty   = (w_count == '0);
    assign w_resp    = bus.mem_i_resp && (r_state == FETCH) && !bus.redirect_valid;

`ifdef FETCH_IQ_BYPASS_EN
    assign w_bypass = w_resp && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response consumed by decode this cycle never touches storage.
    assign w_push      = w_resp && !(w_bypass && bus.iq_ready);
    assign w_pop       = bus.iq_ready && !w_empty && !bus.redirect_valid;
    assign w_countNext = w_count + CW'(w_push) - CW'(w_pop);
    assign w_space     = (w_countNext < CW'(IQ_DEPTH));
    assign w_pushEntry = '{pc: r_addr, instr: bus.mem_i_rdata_cpu};

    fetch_queue #(.IQ_DEPTH(IQ_DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect_valid),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT;
            r_addr  <= RESET_PC;
            r_pend  <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_addr  <= w_addrNext;
            r_pend  <= w_pendNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_addrNext  = r_addr;
        w_pendNext  = r_pend;
        case (r_state)
            WAIT: begin
                if (bus.redirect_valid) begin
                    w_addrNext  = w_redirPc;
                    w_stateNext = FETCH;
                end else if (w_space) begin
                    w_stateNext = FETCH;
                end
            end
            FETCH: begin
                if (bus.redirect_valid && bus.mem_i_resp) begin
                    w_addrNext  = w_redirPc;
                end else if (bus.redirect_valid) begin
                    w_pendNext  = w_redirPc;
                    w_stateNext = DRAIN;
                end else if (bus.mem_i_resp) begin
                    w_addrNext  = r_addr + 32'd4;
                    w_stateNext = w_space ? FETCH : WAIT;
                end
            end
            DRAIN: begin
                // The stale response only releases the bus; the newest redirect target wins.
                if (bus.mem_i_resp) begin
                    w_addrNext  = bus.redirect_valid ? w_redirPc : r_pend;
                    w_stateNext = FETCH;
                end else if (bus.redirect_valid) begin
                    w_pendNext  = w_redirPc;
                end
            end
            default: w_stateNext = WAIT;
        endcase
    end

    assign bus.mem_i_read    = (r_state != WAIT);
    assign bus.mem_i_address = r_addr;
    assign bus.iq_valid      = w_bypass || !w_empty;
    assign bus.iq_instr      = w_bypass ? bus.mem_i_rdata_cpu : (w_empty ? 32'h0 : w_head.instr);
    assign bus.iq_pc         = w_bypass ? r_addr : (w_empty ? 32'h0 : w_head.pc);
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_unit;
    import rv32i_types::*;

    localparam int          IQ_DEPTH = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   age = 0;

    iq_entry_t   mq[$];
    bit          mOut;
    bit          mStale;
    logic [31:0] mOutAddr;
    logic [31:0] mNextPc;

    fetch_unit_if bus();

    fetch_unit #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a list of expected entries plus "is a request outstanding, is it stale".
    task automatic modelStep(input bit resp, input logic [31:0] rdata, input bit redir,
                             input logic [31:0] rpc, input bit ready);
        logic [31:0] target;
        if (rst) begin
            mq.delete();
            mOut = 0; mStale = 0; mNextPc = RESET_PC; mOutAddr = RESET_PC;
            return;
        end
        if (redir) begin
            target = rpc & 32'hFFFF_FFFC;
            mq.delete();
            if (mOut && !resp) begin
                mStale = 1; mNextPc = target;
            end else begin
                mOut = 1; mStale = 0; mOutAddr = target;
            end
        end else begin
            if (ready && mq.size() > 0) void'(mq.pop_front());
            if (mOut && resp) begin
                if (!mStale) begin
                    mq.push_back('{pc: mOutAddr, instr: rdata});
                    mNextPc = mOutAddr + 32'd4;
                end
                mOut = 0;
            end
            if (!mOut && mq.size() < IQ_DEPTH) begin
                mOut = 1; mStale = 0; mOutAddr = mNextPc;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, then settles past the edge.
    task automatic applyStimulus(input bit resp, input logic [31:0] rdata, input bit redir,
                                 input logic [31:0] rpc, input bit ready);
        bus.mem_i_resp      = resp;
        bus.mem_i_rdata_cpu = rdata;
        bus.redirect_valid  = redir;
        bus.redirect_pc     = rpc;
        bus.iq_ready        = ready;
        @(posedge clk);
        modelStep(resp, rdata, redir, rpc, ready);
        #1;
    endtask

    // Memory responder that answers a request once it has been visible for lat cycles.
    task automatic autoCycle(input int lat, input bit ready);
        bit r;
        if (bus.mem_i_read) age++; else age = 0;
        r = bus.mem_i_read && (age >= lat);
        if (r) age = 0;
        applyStimulus(r, $urandom, 1'b0, 32'h0, ready);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
        age = 0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (bus.mem_i_read !== 1'b0) $display("[TB] FAIL reset_read: got %0b want 0", bus.mem_i_read); else passed++;
        checks++; if (bus.mem_i_address !== RESET_PC) $display("[TB] FAIL reset_addr: got %h want %h", bus.mem_i_address, RESET_PC); else passed++;
        checks++; if (bus.iq_valid !== 1'b0) $display("[TB] FAIL reset_iq_valid: got %0b want 0", bus.iq_valid); else passed++;
        checks++; if (bus.iq_instr !== 32'h0) $display("[TB] FAIL reset_iq_instr: got %h want 0", bus.iq_instr); else passed++;
        checks++; if (bus.iq_pc !== 32'h0) $display("[TB] FAIL reset_iq_pc: got %h want 0", bus.iq_pc); else passed++;
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.mem_i_read !== 1'b1 || bus.mem_i_address !== RESET_PC)
            $display("[TB] FAIL first_request: got read=%0b addr=%h want read=1 addr=%h", bus.mem_i_read, bus.mem_i_address, RESET_PC);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] addrLog[$];
        logic [31:0] a;
        doReset();
        for (int c = 0; c < 40 && addrLog.size() < 3; c++) begin
            a = bus.mem_i_address;
            autoCycle(2, 1'b0);
            if (bus.mem_i_resp) begin
                addrLog.push_back(a);
                if (addrLog.size() == 1) begin
                    checks++; if (bus.iq_valid !== 1'b1) $display("[TB] FAIL enq_latency: got iq_valid=%0b want 1", bus.iq_valid); else passed++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (addrLog.size() <= k || addrLog[k] !== RESET_PC + 32'(4 * k))
                $display("[TB] FAIL seq_addr%0d: got %h want %h", k, (addrLog.size() > k) ? addrLog[k] : 32'hx, RESET_PC + 32'(4 * k));
            else passed++;
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== RESET_PC + 32'(4 * k))
                $display("[TB] FAIL seq_pc%0d: got valid=%0b pc=%h want pc=%h", k, bus.iq_valid, bus.iq_pc, RESET_PC + 32'(4 * k));
            else passed++;
            checks++; if (mq.size() == 0 || bus.iq_instr !== mq[0].instr)
                $display("[TB] FAIL seq_instr%0d: got %h want %h", k, bus.iq_instr, (mq.size() > 0) ? mq[0].instr : 32'hx);
            else passed++;
            applyStimulus(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_backpressure();
        int given = 0;
        int given2 = 0;
        doReset();
        for (int c = 0; c < 200; c++) begin
            autoCycle($urandom_range(1, 3), 1'b0);
            given += int'(bus.mem_i_resp);
            if (!bus.mem_i_read) break;
        end
        for (int c = 0; c < 3; c++) begin
            autoCycle(1, 1'b0);
            given += int'(bus.mem_i_resp);
        end
        checks++; if (given != IQ_DEPTH) $display("[TB] FAIL full_accepts: got %0d want %0d", given, IQ_DEPTH); else passed++;
        checks++; if (bus.mem_i_read !== 1'b0) $display("[TB] FAIL full_read: got %0b want 0", bus.mem_i_read); else passed++;
        applyStimulus(0, 0, 0, 0, 1);
        checks++; if (bus.mem_i_read !== 1'b1 || bus.mem_i_address !== 32'h80)
            $display("[TB] FAIL pop_refetch: got read=%0b addr=%h want read=1 addr=00000080", bus.mem_i_read, bus.mem_i_address);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            autoCycle(2, 1'b0);
            given2 += int'(bus.mem_i_resp);
        end
        checks++; if (given2 != 1 || bus.mem_i_read !== 1'b0)
            $display("[TB] FAIL one_refill: got resps=%0d read=%0b want resps=1 read=0", given2, bus.mem_i_read);
        else passed++;
        checks++; if (bus.iq_pc !== 32'h64) $display("[TB] FAIL full_head: got %h want 00000064", bus.iq_pc); else passed++;
    endtask

    task automatic test_redirect_outstanding();
        logic [31:0] d;
        doReset();
        for (int c = 0; c < 40; c++) begin
            if (bus.mem_i_read && bus.mem_i_address == 32'h70) break;
            autoCycle(1, 1'b0);
        end
        applyStimulus(0, 0, 1, 32'h200, 0);
        checks++; if (bus.mem_i_read !== 1'b1 || bus.mem_i_address !== 32'h70 || bus.iq_valid !== 1'b0)
            $display("[TB] FAIL drain_hold: got read=%0b addr=%h valid=%0b want 1/00000070/0", bus.mem_i_read, bus.mem_i_address, bus.iq_valid);
        else passed++;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.mem_i_address !== 32'h70) $display("[TB] FAIL drain_hold2: got %h want 00000070", bus.mem_i_address); else passed++;
        applyStimulus(1, 32'hDEAD_BEEF, 0, 0, 0);
        checks++; if (bus.mem_i_read !== 1'b1 || bus.mem_i_address !== 32'h200 || bus.iq_valid !== 1'b0)
            $display("[TB] FAIL drain_release: got read=%0b addr=%h valid=%0b want 1/00000200/0", bus.mem_i_read, bus.mem_i_address, bus.iq_valid);
        else passed++;
        d = $urandom;
        applyStimulus(1, d, 0, 0, 0);
        checks++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== 32'h200 || bus.iq_instr !== d)
            $display("[TB] FAIL newpath_entry: got valid=%0b pc=%h instr=%h want 1/00000200/%h", bus.iq_valid, bus.iq_pc, bus.iq_instr, d);
        else passed++;
    endtask

    task automatic test_redirect_same_resp();
        doReset();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 32'h1111_1111, 1, 32'h200, 0);
        checks++; if (bus.mem_i_address !== 32'h200 || bus.iq_valid !== 1'b0)
            $display("[TB] FAIL same_resp: got addr=%h valid=%0b want 00000200/0", bus.mem_i_address, bus.iq_valid);
        else passed++;
        applyStimulus(0, 0, 1, 32'h300, 0);
        applyStimulus(0, 0, 1, 32'h400, 0);
        checks++; if (bus.mem_i_address !== 32'h200) $display("[TB] FAIL double_drain_hold: got %h want 00000200", bus.mem_i_address); else passed++;
        applyStimulus(1, 32'h2222_2222, 0, 0, 0);
        checks++; if (bus.mem_i_read !== 1'b1 || bus.mem_i_address !== 32'h400 || bus.iq_valid !== 1'b0)
            $display("[TB] FAIL last_redirect: got read=%0b addr=%h valid=%0b want 1/00000400/0", bus.mem_i_read, bus.mem_i_address, bus.iq_valid);
        else passed++;
    endtask

    task automatic test_align_wrap();
        logic [31:0] d;
        doReset();
        applyStimulus(0, 0, 1, 32'h203, 0);
        checks++; if (bus.mem_i_address !== 32'h200) $display("[TB] FAIL align: got %h want 00000200", bus.mem_i_address); else passed++;
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        applyStimulus(1, 32'h3333_3333, 0, 0, 0);
        checks++; if (bus.mem_i_address !== 32'hFFFF_FFFC) $display("[TB] FAIL top_addr: got %h want fffffffc", bus.mem_i_address); else passed++;
        d = $urandom;
        applyStimulus(1, d, 0, 0, 0);
        checks++; if (bus.mem_i_address !== 32'h0 || bus.iq_pc !== 32'hFFFF_FFFC || bus.iq_instr !== d)
            $display("[TB] FAIL wrap: got addr=%h pc=%h instr=%h want 00000000/fffffffc/%h", bus.mem_i_address, bus.iq_pc, bus.iq_instr, d);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        doReset();
        for (int c = 0; c < 6; c++) autoCycle(1, 1'b0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.mem_i_read !== 1'b0 || bus.mem_i_address !== RESET_PC || bus.iq_valid !== 1'b0 ||
                      bus.iq_instr !== 32'h0 || bus.iq_pc !== 32'h0)
            $display("[TB] FAIL midflight_reset: got read=%0b addr=%h valid=%0b instr=%h pc=%h", bus.mem_i_read,
                     bus.mem_i_address, bus.iq_valid, bus.iq_instr, bus.iq_pc);
        else passed++;
        rst = 1'b0;
        applyStimulus(1, 32'h4444_4444, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.iq_valid !== 1'b0 || bus.mem_i_address !== RESET_PC)
            $display("[TB] FAIL late_resp: got valid=%0b addr=%h want 0/%h", bus.iq_valid, bus.mem_i_address, RESET_PC);
        else passed++;
    endtask

    task automatic test_random();
        bit resp;
        doReset();
        for (int c = 0; c < 1500; c++) begin
            resp = bus.mem_i_read && ($urandom_range(0, 2) == 0);
            applyStimulus(resp, $urandom, $urandom_range(0, 19) == 0, $urandom, 1'($urandom_range(0, 1)));
            checks++; if (bus.mem_i_read !== mOut) $display("[TB] FAIL rnd_read@%0d: got %0b want %0b", c, bus.mem_i_read, mOut); else passed++;
            if (mOut) begin
                checks++; if (bus.mem_i_address !== mOutAddr) $display("[TB] FAIL rnd_addr@%0d: got %h want %h", c, bus.mem_i_address, mOutAddr); else passed++;
            end
            checks++; if (bus.iq_valid !== (mq.size() > 0)) $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", c, bus.iq_valid, mq.size() > 0); else passed++;
            if (mq.size() > 0) begin
                checks++; if (bus.iq_pc !== mq[0].pc || bus.iq_instr !== mq[0].instr)
                    $display("[TB] FAIL rnd_head@%0d: got %h/%h want %h/%h", c, bus.iq_pc, bus.iq_instr, mq[0].pc, mq[0].instr);
                else passed++;
            end
        end
    endtask

    initial begin
        bus.mem_i_resp = 0; bus.mem_i_rdata_cpu = 0; bus.redirect_valid = 0;
        bus.redirect_pc = 0; bus.iq_ready = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_same_resp();
        test_align_wrap();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the out-of-order core; it sits directly upstream of the I-side port of `main_cache`. It generates sequential fetch addresses, drives `mem_i_read`/`mem_i_address` with a hold-until-response handshake, and buffers returned instructions with their PCs in an instruction queue for decode. It accepts redirects from the back end, flushes the queue, and discards any in-flight response belonging to the old path.

## Interface
- `IQ_DEPTH`, default 8: instruction queue entries; must be a power of 2 and at least 2.
- `RESET_PC`, default 32'h0000_0060: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `mem_i_read` out 1: fetch request to the I-cache.
- `mem_i_address` out 32: fetch address; always word aligned.
- `mem_i_resp` in 1: one-cycle response pulse from the I-cache.
- `mem_i_rdata_cpu` in 32: instruction word; valid when `mem_i_resp`=1.
- `redirect_valid` in 1: back end redirects fetch this cycle.
- `redirect_pc` in 32: redirect target; bits [1:0] are forced to 0.
- `iq_valid` out 1: head entry valid.
- `iq_instr` out 32: head instruction.
- `iq_pc` out 32: head PC.
- `iq_ready` in 1: decode pops the head when `iq_valid`&&`iq_ready`.

## Operation
- State machine `fetch_state_t`:
  - WAIT: no request outstanding.
  - FETCH: request outstanding on the current path.
  - DRAIN: request outstanding on a stale path; its response is discarded.
- `mem_i_read`=1 in FETCH and DRAIN. `mem_i_address` is the registered request address; it is held constant until `mem_i_resp`.
- At most one request is outstanding. A request is issued only when the queue has a free slot after this cycle's pop, so every accepted response always fits.
- WAIT → FETCH when there is space. Otherwise stay in WAIT.
- FETCH with `mem_i_resp`:
  - Enqueue {`pc`=address, `instr`=rdata}.
  - Set next address = address+4 (32-bit wrap; 32'hFFFF_FFFC → 0).
  - Stay in FETCH if space remains after the enqueue and pop; otherwise go to WAIT.
- Redirect has priority over enqueue and pop:
  - The queue is cleared, with any same-cycle pop ignored.
  - The pending PC is set to `redirect_pc`.
  - In FETCH without a same-cycle resp → DRAIN.
  - In FETCH with a same-cycle resp → the data is discarded; next state is FETCH at `redirect_pc`.
  - In WAIT → FETCH at `redirect_pc` next cycle.
  - In DRAIN → stay in DRAIN and update the pending PC (last redirect wins).
- DRAIN: the old address stays on the bus until `mem_i_resp`. That response is dropped; next state is FETCH with the address set to the pending PC.
- Pop with an empty queue is ignored. Count arithmetic uses $clog2(IQ_DEPTH)+1 bits. Head and tail pointers wrap modulo IQ_DEPTH.

## Timing
- Reset values:
  - `mem_i_read`=0, `mem_i_address`=RESET_PC.
  - `iq_valid`=0, `iq_instr`=0, `iq_pc`=0.
  - state=WAIT, count=0.
- `rst` asserted mid-transaction aborts immediately. Any later `mem_i_resp` for that request is ignored in WAIT.
- First `mem_i_read`=1 occurs in the first cycle after `rst` deasserts.
- Enqueue-to-`iq_valid` latency is 1 cycle.
- Back-to-back fetch: `mem_i_read` stays high across the resp edge and the new address appears the next cycle, with no idle cycle when space exists.
- Redirect to first new-path request:
  - 1 cycle from WAIT or FETCH.
  - From DRAIN, 1 cycle after the stale `mem_i_resp`.
- Simultaneous enqueue and pop at full (count=IQ_DEPTH) cannot occur, because no request is outstanding when full.

## Configuration
- `FETCH_IQ_BYPASS_EN` defined:
  - When the queue is empty and `mem_i_resp` arrives on the current path, `iq_valid`/`iq_instr`/`iq_pc` present the response combinationally in the same cycle.
  - If `iq_ready`=1 the entry is not written; otherwise it is enqueued normally.
  - Redirect in the same cycle suppresses the bypass.
- Undefined: all outputs come from queue storage only, with a fixed 1-cycle latency.

## Structure
- In `rv32i_types`:
  - `fetch_state_t` enum {WAIT, FETCH, DRAIN}.
  - `iq_entry_t` packed struct {pc[31:0], instr[31:0]}.
- One sub-module, `fetch_queue`:
  - Circular FIFO of `iq_entry_t`.
  - Ports: push, pop, flush, count, head outputs.
- The FSM and PC logic live in `fetch_unit`.

## Test plan
- Reset, then a memory model responding 2 cycles after each request → addresses 0x60, 0x64, 0x68 in order; `iq_pc` matches and `iq_instr` equals the model data.
- `iq_ready`=0 with IQ_DEPTH=8 → exactly 8 responses accepted; `mem_i_read` drops to 0 with count=8. One pop → exactly one new request issued.
- Redirect to 0x200 while a request to 0x70 is outstanding:
  - 0x70 is held until resp and its data is never enqueued.
  - The next request is 0x200 and the queue is empty immediately after the redirect.
- Redirect in the same cycle as `mem_i_resp` → that data is dropped and the next address is 0x200. Two redirects during DRAIN (0x300, then 0x400) → the next fetch is 0x400.
- `redirect_pc`=0x203 → fetch at 0x200. Redirect to 0xFFFF_FFFC → next sequential fetch at 0x0000_0000.
- `rst` asserted while a request is pending → all outputs return to their reset values next cycle, and a late `mem_i_resp` produces no enqueue.
